// File: rtl/vnu_pkg.sv
// Shared types and sizing helpers for the variable-node update blocks.
package vnu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  // Largest magnitude an extrinsic message may carry (symmetric range).
  function automatic int sat_limit(input int data_width);
    return (32'sd1 <<< (data_width - 32'sd1)) - 32'sd1;
  endfunction

  // Accumulator wide enough for the LLR plus dv messages without overflow.
  function automatic int acc_width(input int data_width, input int dv);
    return data_width + $clog2(dv + 32'sd1);
  endfunction

endpackage

// File: rtl/T_to_S.sv
// Two's-complement to sign-magnitude converter; the output MSB is the sign.
module T_to_S #(
  parameter int DATA_WIDTH = 6
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH:0]   dout
);

  // Negative inputs are negated to recover the magnitude.
  always_comb begin
    if (din[DATA_WIDTH-1]) begin
      dout = {1'b1, (~din + 1'b1)};
    end else begin
      dout = {1'b0, din};
    end
  end

endmodule

// File: rtl/vnu_serial_ctrl.sv
// Serial variable-node controller: accumulates LLR plus DV check messages,
// then streams DV saturated sign-magnitude extrinsics and the hard decision.
module vnu_serial_ctrl
  import vnu_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int DV         = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH:0]     out_data,
  output logic [$clog2(DV)-1:0]   out_idx,
  output logic                    out_last,
  output logic                    out_hard
);

  localparam int AW = acc_width(DATA_WIDTH, DV);
  localparam int IW = $clog2(DV);
  localparam logic [IW-1:0]        LAST_IDX = IW'(DV - 1);
  localparam logic signed [AW-1:0] POS_LIM  = AW'(sat_limit(DATA_WIDTH));
  localparam logic signed [AW-1:0] NEG_LIM  = -POS_LIM;

  state_t                 state_r;
  logic [IW-1:0]          cnt_r;
  logic [IW-1:0]          idx_r;
  logic signed [AW-1:0]   total_r;
  logic [DATA_WIDTH-1:0]  msg_r [DV];

  logic signed [AW-1:0]   in_ext_s;
  logic signed [AW-1:0]   msg_ext_s;
  logic signed [AW-1:0]   ext_s;
  logic [DATA_WIDTH-1:0]  sat_s;
  logic [DATA_WIDTH:0]    sm_s;
  logic                   emit_s;

  assign in_ext_s  = {{(AW-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  assign msg_ext_s = {{(AW-DATA_WIDTH){msg_r[idx_r][DATA_WIDTH-1]}}, msg_r[idx_r]};
  assign ext_s     = total_r - msg_ext_s;

  // Symmetric clamp so the most negative code is never produced.
  always_comb begin
    if (ext_s > POS_LIM) begin
      sat_s = POS_LIM[DATA_WIDTH-1:0];
    end else if (ext_s < NEG_LIM) begin
      sat_s = NEG_LIM[DATA_WIDTH-1:0];
    end else begin
      sat_s = ext_s[DATA_WIDTH-1:0];
    end
  end

  T_to_S #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_t_to_s (
    .din  (sat_s),
    .dout (sm_s)
  );

  // Node sequencer: collect DV+1 input beats, then hand out DV extrinsics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      total_r <= '0;
      for (int i = 0; i < DV; i++) begin
        msg_r[i] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            total_r <= in_ext_s;
            cnt_r   <= '0;
            state_r <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            msg_r[cnt_r] <= in_data;
            total_r      <= total_r + in_ext_s;
            if (cnt_r == LAST_IDX) begin
              cnt_r   <= '0;
              idx_r   <= '0;
              state_r <= EMIT;
            end else begin
              cnt_r <= cnt_r + IW'(1);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (idx_r == LAST_IDX) begin
              idx_r   <= '0;
              state_r <= IDLE;
            end else begin
              idx_r <= idx_r + IW'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Reset gates the handshakes immediately, before the state register clears.
  assign emit_s    = (state_r == EMIT) && !rst;
  assign in_ready  = !rst && ((state_r == IDLE) || (state_r == ACCUM));
  assign out_valid = emit_s;
  assign out_data  = emit_s ? sm_s : '0;
  assign out_idx   = emit_s ? idx_r : '0;
  assign out_last  = emit_s && (idx_r == LAST_IDX);
  assign out_hard  = emit_s && total_r[AW-1];

endmodule

// File: tb/tb_vnu_serial_ctrl.sv
// Directed self-checking bench for vnu_serial_ctrl at DATA_WIDTH=6, DV=3.
module tb_vnu_serial_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_data;
  logic [1:0] out_idx;
  logic       out_last;
  logic       out_hard;

  int checks = 0;
  int errors = 0;

  vnu_serial_ctrl #(
    .DATA_WIDTH(6),
    .DV(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_hard  (out_hard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one input beat and wait (bounded) for its handshake.
  task automatic send(input logic [5:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_node(input logic [5:0] llr, input logic [5:0] m0,
                           input logic [5:0] m1, input logic [5:0] m2);
    send(llr);
    send(m0);
    send(m1);
    send(m2);
  endtask

  // Check the presented extrinsic beat, then take it.
  task automatic recv(input string tag, input logic [6:0] d, input logic [1:0] i,
                      input logic l, input logic h);
    out_ready = 1'b1;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"},  {25'd0, out_data},  {25'd0, d});
    chk({tag, "_idx"},   {30'd0, out_idx},   {30'd0, i});
    chk({tag, "_last"},  {31'd0, out_last},  {31'd0, l});
    chk({tag, "_hard"},  {31'd0, out_hard},  {31'd0, h});
    chk({tag, "_inrdy"}, {31'd0, in_ready},  32'd0);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 6'd0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {25'd0, out_data}, 32'd0);
    chk("rst_out_hard", {31'd0, out_hard}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Node 1: LLR 5, msgs 3,-2,4 -> total 10, extrinsics 7,12,6
    out_ready = 1'b1;
    send_node(6'sd5, 6'sd3, -6'sd2, 6'sd4);
    chk("n1_latency_valid", {31'd0, out_valid}, 32'd1);
    recv("n1b0", 7'b0000111, 2'd0, 1'b0, 1'b0);
    recv("n1b1", 7'b0001100, 2'd1, 1'b0, 1'b0);
    recv("n1b2", 7'b0000110, 2'd2, 1'b1, 1'b0);
    chk("n1_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("n1_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("n1_idle_data", {25'd0, out_data}, 32'd0);

    // Node 2: total -43, extrinsics -28, -33->-31, -45->-31
    send_node(-6'sd20, -6'sd15, -6'sd10, 6'sd2);
    recv("n2b0", 7'b1011100, 2'd0, 1'b0, 1'b1);
    recv("n2b1", 7'b1011111, 2'd1, 1'b0, 1'b1);
    recv("n2b2", 7'b1011111, 2'd2, 1'b1, 1'b1);

    // Positive and negative full-scale saturation
    send_node(6'sd31, 6'sd31, 6'sd31, 6'sd31);
    recv("n3b0", 7'b0011111, 2'd0, 1'b0, 1'b0);
    recv("n3b1", 7'b0011111, 2'd1, 1'b0, 1'b0);
    recv("n3b2", 7'b0011111, 2'd2, 1'b1, 1'b0);
    send_node(6'b100000, 6'b100000, 6'b100000, 6'b100000);
    recv("n4b0", 7'b1011111, 2'd0, 1'b0, 1'b1);
    recv("n4b1", 7'b1011111, 2'd1, 1'b0, 1'b1);
    recv("n4b2", 7'b1011111, 2'd2, 1'b1, 1'b1);

    // Backpressure: stall 4 cycles on beat 1
    send_node(6'sd5, 6'sd3, -6'sd2, 6'sd4);
    recv("n5b0", 7'b0000111, 2'd0, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", {25'd0, out_data}, {25'd0, 7'b0001100});
      chk("stall_idx", {30'd0, out_idx}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    recv("n5b1", 7'b0001100, 2'd1, 1'b0, 1'b0);
    recv("n5b2", 7'b0000110, 2'd2, 1'b1, 1'b0);

    // Reset during EMIT beat 1 discards the node
    send_node(6'sd5, 6'sd3, -6'sd2, 6'sd4);
    recv("n6b0", 7'b0000111, 2'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_out_data", {25'd0, out_data}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("after_rst_out_valid", {31'd0, out_valid}, 32'd0);
    send_node(6'sd1, 6'sd0, 6'sd0, 6'sd0);
    recv("n7b0", 7'b0000001, 2'd0, 1'b0, 1'b0);
    recv("n7b1", 7'b0000001, 2'd1, 1'b0, 1'b0);
    recv("n7b2", 7'b0000001, 2'd2, 1'b1, 1'b0);

    // Back-to-back nodes with in_valid held high throughout
    in_valid = 1'b1;
    in_data  = 6'sd5;
    tick();
    in_data = 6'sd3;
    tick();
    in_data = -6'sd2;
    tick();
    in_data = 6'sd4;
    tick();
    in_data = 6'sd1;
    recv("b2b_b0", 7'b0000111, 2'd0, 1'b0, 1'b0);
    recv("b2b_b1", 7'b0001100, 2'd1, 1'b0, 1'b0);
    recv("b2b_b2", 7'b0000110, 2'd2, 1'b1, 1'b0);
    chk("b2b_next_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_data = 6'sd0;
    chk("b2b_accum_ready", {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    recv("b2b2_b0", 7'b0000001, 2'd0, 1'b0, 1'b0);
    recv("b2b2_b1", 7'b0000001, 2'd1, 1'b0, 1'b0);
    recv("b2b2_b2", 7'b0000001, 2'd2, 1'b1, 1'b0);
    chk("final_idle_valid", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
